// File: rtl/ring_tap_monitor.sv
// ring_tap_monitor: synchronous observer for a free-running ring oscillator node.
// Synchronises the asynchronous tap, counts rising edges over a programmable
// window of clock cycles, and flags a ring that has stopped toggling.
module ring_tap_monitor #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 16,
  parameter int WIN_W        = 16,
  parameter int STALL_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring_tap,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             stalled
);

  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   tap_s;
  logic                   prev;
  logic                   rise;
  logic                   any_edge;
  logic [SW-1:0]          scnt;
  logic [WIN_W-1:0]       rem;
  logic [CNT_W-1:0]       ecnt;
  logic                   ovf_acc;

  assign tap_s    = sync[SYNC_STAGES-1];
  assign rise     = tap_s & ~prev;
  assign any_edge = tap_s ^ prev;

  // Tap synchroniser chain plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ring_tap};
      prev <= tap_s;
    end
  end

  // Stall detector: cycles since last tap transition, saturating; free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt    <= '0;
      stalled <= 1'b0;
    end else begin
      if (any_edge)
        scnt <= '0;
      else if (scnt != STALL_MAX)
        scnt <= scnt + 1'b1;
      stalled <= (scnt == STALL_MAX);
    end
  end

  // Measurement FSM; busy and result outputs are registered off the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      ecnt        <= '0;
      ovf_acc     <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      busy        <= (state != IDLE);
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem     <= window;
            ecnt    <= '0;
            ovf_acc <= 1'b0;
            state   <= (window == '0) ? DONE : COUNT;
          end
        end
        COUNT: begin
          // Saturate rather than wrap; remember that it happened.
          if (rise) begin
            if (ecnt == CNT_MAX)
              ovf_acc <= 1'b1;
            else
              ecnt <= ecnt + 1'b1;
          end
          rem <= rem - 1'b1;
          if (rem == WIN_W'(1))
            state <= DONE;
        end
        DONE: begin
          count       <= ecnt;
          overflow    <= ovf_acc;
          count_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_tap_monitor.sv
// Bench for ring_tap_monitor: two instances (wide counter / 2-stage sync and
// narrow counter / 3-stage sync) share stimulus and are checked against a
// model built from the per-cycle history of sampled tap values.
module tb_ring_tap_monitor;
  localparam int STALL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ring_tap = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window = '0;

  logic        busy_a, cv_a, ovf_a, st_a;
  logic [15:0] cnt_a;
  logic        busy_b, cv_b, ovf_b, st_b;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  int gcyc  = 0;
  int base  = 0;
  bit samp [0:16383];

  ring_tap_monitor #(.SYNC_STAGES(2), .CNT_W(16), .WIN_W(16), .STALL_CYCLES(STALL)) u_a (
    .clk(clk), .rst_n(rst_n), .ring_tap(ring_tap), .start(start), .window(window),
    .busy(busy_a), .count(cnt_a), .count_valid(cv_a), .overflow(ovf_a), .stalled(st_a));

  ring_tap_monitor #(.SYNC_STAGES(3), .CNT_W(4), .WIN_W(16), .STALL_CYCLES(STALL)) u_b (
    .clk(clk), .rst_n(rst_n), .ring_tap(ring_tap), .start(start), .window(window),
    .busy(busy_b), .count(cnt_b), .count_valid(cv_b), .overflow(ovf_b), .stalled(st_b));

  always #5 clk = ~clk;

  // Record the tap value seen at every clock edge; edges under reset mark the epoch.
  always @(posedge clk) begin
    gcyc = gcyc + 1;
    if (!rst_n) base = gcyc;
    if (gcyc < 16384) samp[gcyc] = ring_tap;
  end

  function automatic int smp(int i);
    return (i <= base || i < 0) ? 0 : int'(samp[i]);
  endfunction

  // Synchronised tap value after edge n for an s-stage synchroniser.
  function automatic int tap_s(int n, int s);
    return smp(n - s + 1);
  endfunction

  // Cycles since the last visible tap transition (or reset), capped at STALL.
  function automatic int age(int n, int s);
    for (int d = 0; d < STALL; d++) begin
      if (n - d <= base) return d;
      if (tap_s(n - d - 1, s) != tap_s(n - d - 2, s)) return d;
    end
    return STALL;
  endfunction

  // Rising edges observed over the window's edges k+1..k+w, saturated at cw bits.
  task automatic exp_cnt(input int k, input int w, input int s, input int cw,
                         output int c, output int o);
    int mx;
    mx = (1 << cw) - 1;
    c = 0;
    o = 0;
    for (int e = k + 1; e <= k + w; e++) begin
      if (tap_s(e - 1, s) == 1 && tap_s(e - 2, s) == 0) begin
        if (c == mx) o = 1;
        else c++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_tap();
    case (mode)
      1: ring_tap = ~ring_tap;
      2: ring_tap = ((gcyc >> 2) & 1) != 0;
      3: ring_tap = ($urandom % 2) != 0;
      4: ring_tap = ((gcyc / 3) % 2) != 0;
      default: ;
    endcase
  endtask

  // One clock: check the stall flags against the model, then move the tap.
  task automatic step();
    @(posedge clk);
    #1;
    chk("stalled_a", {31'd0, st_a}, {31'd0, age(gcyc - 1, 2) >= STALL});
    chk("stalled_b", {31'd0, st_b}, {31'd0, age(gcyc - 1, 3) >= STALL});
    drive_tap();
  endtask

  task automatic run_win(input int w, input int restart_at);
    int k, ca, oa, cb, ob;
    window = 16'(w);
    start  = 1'b1;
    k      = gcyc + 1;
    step();
    start  = 1'b0;
    chk("busy_at_start", {30'd0, busy_a, busy_b}, 32'd0);
    for (int c = 1; c <= w + 2; c++) begin
      start = (c == restart_at);
      step();
      chk("busy_a", {31'd0, busy_a}, {31'd0, c <= w + 1});
      chk("busy_b", {31'd0, busy_b}, {31'd0, c <= w + 1});
      chk("cvalid_a", {31'd0, cv_a}, {31'd0, c == w + 1});
      chk("cvalid_b", {31'd0, cv_b}, {31'd0, c == w + 1});
      if (c == w + 1) begin
        exp_cnt(k, w, 2, 16, ca, oa);
        exp_cnt(k, w, 3, 4, cb, ob);
        chk("count_a", {16'd0, cnt_a}, ca);
        chk("ovf_a", {31'd0, ovf_a}, oa);
        chk("count_b", {28'd0, cnt_b}, cb);
        chk("ovf_b", {31'd0, ovf_b}, ob);
      end
    end
    start = 1'b0;
    exp_cnt(k, w, 2, 16, ca, oa);
    chk("count_hold_a", {16'd0, cnt_a}, ca);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy_a, cv_a, ovf_a, st_a, busy_b, cv_b, ovf_b, st_b}, 32'd0);
    chk({tag, "_cnt"}, {12'd0, cnt_a, cnt_b}, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;

    // Constant tap: stall asserts, then one toggle clears and re-arms it.
    mode = 0;
    repeat (70) step();
    chk("stall_hi_a", {31'd0, st_a}, 32'd1);
    ring_tap = ~ring_tap;
    repeat (75) step();

    // Directed windows from the test plan.
    mode = 2; run_win(80, 0);
    run_win(0, 0);
    mode = 1; run_win(64, 0);
    mode = 2; run_win(16, 0);
    run_win(40, 10);

    // Randomised windows and tap patterns.
    for (int r = 0; r < 8; r++) begin
      mode = 1 + int'($urandom_range(0, 3));
      run_win(int'($urandom_range(0, 70)), 0);
    end

    // Reset in the middle of a window aborts it.
    mode   = 2;
    window = 16'd80;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (30) step();
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("no_cv_after_rst", {30'd0, cv_a, cv_b}, 32'd0);
    end
    mode = 3;
    run_win(20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ring_tap_monitor.md
Name: ring_tap_monitor

Overview:
- Synchronous observer for the free-running inverter/buffer ring model; sits directly downstream of one ring node.
- Samples the asynchronous tap through a synchroniser and counts rising edges over a programmable window of clock cycles.
- Flags a stalled (non-oscillating) ring so benches and on-chip checkers can confirm the ring is live and estimate its period.

Parameters:
- SYNC_STAGES, 2, number of flops in the tap synchroniser (min 2).
- CNT_W, 16, width of the edge-count result.
- WIN_W, 16, width of the window-length input.
- STALL_CYCLES, 64, clock cycles without any tap edge before `stalled` asserts (min 1).

Ports:
- clk  input  1  single system clock; all state on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ring_tap  input  1  ring node output, asynchronous to clk.
- start  input  1  request a measurement; sampled only in IDLE.
- window  input  WIN_W  measurement length in clk cycles; latched on accepted start.
- busy  output  1  high in COUNT and DONE.
- count  output  CNT_W  rising-edge count of the last completed window; holds until the next DONE.
- count_valid  output  1  one-cycle pulse when `count` updates.
- overflow  output  1  last window's count saturated; updated together with `count`.
- stalled  output  1  no tap edge seen for STALL_CYCLES cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - synchroniser flops, previous-sample flop, stall counter, window counter and edge counter all clear to 0.
  - FSM goes to IDLE; busy, count, count_valid, overflow and stalled are all 0.
  - Reset mid-window aborts the window; no count_valid is produced after release.
- Synchroniser and edge detection:
  - ring_tap passes through SYNC_STAGES flops to give tap_s.
  - prev is tap_s delayed one cycle.
  - rise = tap_s & ~prev; any_edge = tap_s ^ prev.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - On start=1, latch window into rem and clear the edge counter and overflow accumulator.
  - If window!=0, go to COUNT; if window==0, go straight to DONE.
- COUNT:
  - Stays exactly W cycles (W = latched window).
  - Each cycle with rise=1 increments the edge counter. The increment saturates at 2^CNT_W-1 and sets the overflow accumulator.
  - rem decrements every cycle; when rem==1, go to DONE.
- DONE (one cycle):
  - count <= edge counter; overflow <= accumulator; count_valid=1.
  - Next state is IDLE.
- Latency: with start sampled at clock edge k, count_valid is high during the cycle that begins at edge k+W+1. W=0 gives count_valid one cycle after start, with count=0.
- start is ignored in COUNT and DONE. A start held high through DONE is accepted in the following IDLE cycle (back-to-back windows, one idle cycle between them).
- ring_tap changes during COUNT are counted only via rise. Edges still inside the synchroniser when the window closes are not counted.
- Stall detector:
  - Runs independently of the FSM.
  - The counter clears on any_edge and otherwise increments, saturating at STALL_CYCLES.
  - stalled = (counter == STALL_CYCLES), registered.
  - stalled clears the cycle after the first any_edge.
- Width rules: rem is WIN_W bits; window=2^WIN_W-1 is legal; no wrap of rem or count.

Test Plan:
- ring_tap square wave, 4 clk high / 4 clk low (period 8), start with window=80 -> count_valid at edge k+81, count=10, overflow=0, busy high k+1..k+81.
- start with window=0 -> count_valid one cycle after the start edge, count=0, busy high for exactly 1 cycle.
- CNT_W=4, ring_tap toggling every clk (period 2), window=64 -> count=15, overflow=1. A following window=16 run with period 8 gives count=2, overflow=0.
- ring_tap held constant from reset -> stalled=1 at cycle 64; one toggle of ring_tap -> stalled=0 SYNC_STAGES+2 cycles later, re-asserts 64 cycles after that edge.
- rst_n pulsed low at cycle 30 of a window=80 run -> all outputs 0 immediately; after release no count_valid appears until a new start.
- start pulsed again at cycle 10 of a window=40 run -> ignored: single count_valid at k+41, count matches the original run.
